// File: rtl/sfp_aurora_pkg.sv
// Shared types and helpers for the Aurora-side AXIS framer: TX state encoding,
// beat-index sizing and the bit offset of a beat inside the stream word.
package sfp_aurora_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_DONE
  } tx_state_e;

  // Beat counters never shrink below one bit, even for degenerate beat counts.
  function automatic int beat_idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Beat k occupies stream bits [(k+1)*w-1 : k*w]; beat 0 holds the LSBs.
  function automatic int beat_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sfp_aurora_axis_framer_if.sv
// AXI4-Stream beat bundle shared by the Aurora TX and RX user interfaces.
interface sfp_aurora_axis_framer_if #(
  parameter int C_AXIS_TDATA_WIDTH = 64
);

  logic [C_AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] tkeep;
  logic                            tvalid;
  logic                            tlast;
  logic                            tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/sfp_aurora_rx_assembler.sv
// Reassembles a fixed-length Aurora RX AXIS frame into one stream word and
// flags frames whose length does not match the expected beat count.
module sfp_aurora_rx_assembler
  import sfp_aurora_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_BEATS            = 3,
  localparam int C_DATA_BIT        = C_AXIS_TDATA_WIDTH * C_BEATS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_channel_up,
  sfp_aurora_axis_framer_if.slave       s_axis,
  output logic [C_DATA_BIT-1:0]         o_rx_stream_data,
  output logic                          o_rx_end_flag,
  output logic                          o_rx_len_err
);

  localparam int                IDX_W    = beat_idx_width(C_BEATS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(C_BEATS - 1);

  logic [IDX_W-1:0]      cnt;
  logic                  dropping;
  logic [C_DATA_BIT-1:0] shadow;
  logic [C_DATA_BIT-1:0] next_word;

  // The Aurora RX user interface has no backpressure.
  assign s_axis.tready = 1'b1;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    next_word = shadow;
    next_word[beat_lsb(int'(cnt), C_AXIS_TDATA_WIDTH) +: C_AXIS_TDATA_WIDTH] = s_axis.tdata;
  end

  // NOTE: the shadow buffer is pure datapath and is fully rewritten before use, so it has no reset.
  always_ff @(posedge i_clk) begin
    if (s_axis.tvalid && !dropping) begin
      shadow <= next_word;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt              <= '0;
      dropping         <= 1'b0;
      o_rx_stream_data <= '0;
      o_rx_end_flag    <= 1'b0;
      o_rx_len_err     <= 1'b0;
    end else begin
      o_rx_end_flag <= 1'b0;
      o_rx_len_err  <= 1'b0;

      if (!i_channel_up) begin
        // Channel loss silently discards any partial frame.
        cnt      <= '0;
        dropping <= 1'b0;
      end else if (s_axis.tvalid) begin
        if (dropping) begin
          if (s_axis.tlast) begin
            dropping <= 1'b0;
          end
        end else if (s_axis.tlast) begin
          if (cnt == LAST_IDX) begin
            o_rx_stream_data <= next_word;
            o_rx_end_flag    <= 1'b1;
          end else begin
            o_rx_len_err <= 1'b1;
          end
          cnt <= '0;
        end else if (cnt == LAST_IDX) begin
          // Overlong frame: report once, then swallow beats up to its tlast.
          o_rx_len_err <= 1'b1;
          dropping     <= 1'b1;
          cnt          <= '0;
        end else begin
          cnt <= cnt + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sfp_aurora_axis_framer.sv
// Bridges the SFP data handler (stream word + flags) to the Aurora 64B/66B AXIS
// user interface: TX serialises one word per start edge, RX reassembles frames.
module sfp_aurora_axis_framer
  import sfp_aurora_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_NUMBER_OF_SLAVE  = 3,
  parameter int C_NUMBER_OF_FRAME  = 1,
  localparam int C_BEATS           = C_NUMBER_OF_SLAVE * C_NUMBER_OF_FRAME,
  localparam int C_DATA_BIT        = C_AXIS_TDATA_WIDTH * C_BEATS
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_channel_up,
  input  logic                    i_tx_start_flag,
  input  logic [C_DATA_BIT-1:0]   i_tx_stream_data,
  output logic                    o_tx_busy,
  output logic                    o_tx_done,
  output logic                    o_tx_abort,
  sfp_aurora_axis_framer_if.master m_axis_tx,
  sfp_aurora_axis_framer_if.slave  s_axis_rx,
  output logic [C_DATA_BIT-1:0]   o_rx_stream_data,
  output logic                    o_rx_end_flag,
  output logic                    o_rx_len_err
);

  localparam int                IDX_W    = beat_idx_width(C_BEATS);
  localparam int                KEEP_W   = C_AXIS_TDATA_WIDTH / 8;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(C_BEATS - 1);

  tx_state_e             state;
  logic [IDX_W-1:0]      beat_idx;
  logic [IDX_W-1:0]      next_idx;
  logic [C_DATA_BIT-1:0] tx_word;
  logic                  start_d;
  logic                  start_edge;

  assign start_edge = i_tx_start_flag && !start_d;
  assign next_idx   = beat_idx + IDX_W'(1);

  // Partial beats are never produced, so keep simply mirrors valid.
  assign m_axis_tx.tkeep = {KEEP_W{m_axis_tx.tvalid}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= TX_IDLE;
      beat_idx         <= '0;
      tx_word          <= '0;
      start_d          <= 1'b0;
      o_tx_busy        <= 1'b0;
      o_tx_done        <= 1'b0;
      o_tx_abort       <= 1'b0;
      m_axis_tx.tdata  <= '0;
      m_axis_tx.tvalid <= 1'b0;
      m_axis_tx.tlast  <= 1'b0;
    end else begin
      // The edge detector keeps tracking in every state so a held level never retriggers.
      start_d    <= i_tx_start_flag;
      o_tx_done  <= 1'b0;
      o_tx_abort <= 1'b0;

      unique case (state)
        TX_IDLE: begin
          if (start_edge && i_channel_up) begin
            tx_word          <= i_tx_stream_data;
            beat_idx         <= '0;
            m_axis_tx.tdata  <= i_tx_stream_data[C_AXIS_TDATA_WIDTH-1:0];
            m_axis_tx.tvalid <= 1'b1;
            m_axis_tx.tlast  <= (C_BEATS == 1);
            o_tx_busy        <= 1'b1;
            state            <= TX_SEND;
          end
        end

        TX_SEND: begin
          if (!i_channel_up) begin
            m_axis_tx.tvalid <= 1'b0;
            m_axis_tx.tlast  <= 1'b0;
            o_tx_abort       <= 1'b1;
            o_tx_busy        <= 1'b0;
            state            <= TX_IDLE;
          end else if (m_axis_tx.tready) begin
            if (beat_idx == LAST_IDX) begin
              m_axis_tx.tvalid <= 1'b0;
              m_axis_tx.tlast  <= 1'b0;
              o_tx_done        <= 1'b1;
              o_tx_busy        <= 1'b0;
              state            <= TX_DONE;
            end else begin
              beat_idx         <= next_idx;
              m_axis_tx.tdata  <= tx_word[beat_lsb(int'(next_idx), C_AXIS_TDATA_WIDTH) +: C_AXIS_TDATA_WIDTH];
              m_axis_tx.tlast  <= (next_idx == LAST_IDX);
            end
          end
        end

        TX_DONE: begin
          state <= TX_IDLE;
        end

        default: begin
          state <= TX_IDLE;
        end
      endcase
    end
  end

  sfp_aurora_rx_assembler #(
    .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
    .C_BEATS            (C_BEATS)
  ) u_rx_assembler (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_channel_up     (i_channel_up),
    .s_axis           (s_axis_rx),
    .o_rx_stream_data (o_rx_stream_data),
    .o_rx_end_flag    (o_rx_end_flag),
    .o_rx_len_err     (o_rx_len_err)
  );

endmodule

// File: tb/tb_sfp_aurora_axis_framer.sv
// Directed bench for sfp_aurora_axis_framer: a TX cycle table plus hand-written
// sequences for level-hold, channel abort, RX framing errors and reset.
module tb_sfp_aurora_axis_framer;

  localparam int W    = 64;
  localparam int NB   = 3;
  localparam int DW   = W * NB;
  localparam int NVEC = 17;

  localparam logic [W-1:0] B0 = 64'h1111_0000_0000_0001;
  localparam logic [W-1:0] B1 = 64'h2222_0000_0000_0002;
  localparam logic [W-1:0] B2 = 64'h3333_0000_0000_0003;

  localparam logic [W-1:0] RA = 64'hAAAA_0000_0000_000A;
  localparam logic [W-1:0] RB = 64'hBBBB_0000_0000_000B;
  localparam logic [W-1:0] RC = 64'hCCCC_0000_0000_000C;
  localparam logic [W-1:0] RJ = 64'h0101_0000_0000_0011;
  localparam logic [W-1:0] RK = 64'h0202_0000_0000_0022;
  localparam logic [W-1:0] RL = 64'h0303_0000_0000_0033;
  localparam logic [W-1:0] RN = 64'h0404_0000_0000_0044;
  localparam logic [W-1:0] RO = 64'h0505_0000_0000_0055;
  localparam logic [W-1:0] RP = 64'h0606_0000_0000_0066;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_channel_up;
  logic          i_tx_start_flag;
  logic [DW-1:0] i_tx_stream_data;
  logic          o_tx_busy;
  logic          o_tx_done;
  logic          o_tx_abort;
  logic [DW-1:0] o_rx_stream_data;
  logic          o_rx_end_flag;
  logic          o_rx_len_err;

  sfp_aurora_axis_framer_if #(.C_AXIS_TDATA_WIDTH(W)) tx_if ();
  sfp_aurora_axis_framer_if #(.C_AXIS_TDATA_WIDTH(W)) rx_if ();

  sfp_aurora_axis_framer #(
    .C_AXIS_TDATA_WIDTH (W),
    .C_NUMBER_OF_SLAVE  (3),
    .C_NUMBER_OF_FRAME  (1)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_channel_up     (i_channel_up),
    .i_tx_start_flag  (i_tx_start_flag),
    .i_tx_stream_data (i_tx_stream_data),
    .o_tx_busy        (o_tx_busy),
    .o_tx_done        (o_tx_done),
    .o_tx_abort       (o_tx_abort),
    .m_axis_tx        (tx_if.master),
    .s_axis_rx        (rx_if.slave),
    .o_rx_stream_data (o_rx_stream_data),
    .o_rx_end_flag    (o_rx_end_flag),
    .o_rx_len_err     (o_rx_len_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic         start;
    logic         ready;
    logic         up;
    logic         valid;
    logic         last;
    logic         busy;
    logic         done;
    logic [W-1:0] data;
  } tx_vec_t;

  tx_vec_t vec [NVEC];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs change there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rx_beat(input logic [W-1:0] data, input logic last);
    rx_if.tdata  = data;
    rx_if.tvalid = 1'b1;
    rx_if.tlast  = last;
    tick();
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
  endtask

  task automatic check_tx(input string name, input logic valid, input logic last,
                          input logic busy, input logic done, input logic [W-1:0] data);
    check({name, "_valid"}, tx_if.tvalid, valid);
    check({name, "_last"},  tx_if.tlast,  last);
    check({name, "_busy"},  o_tx_busy,    busy);
    check({name, "_done"},  o_tx_done,    done);
    check({name, "_keep"},  tx_if.tkeep,  valid ? 8'hFF : 8'h00);
    if (valid) check({name, "_data"}, tx_if.tdata, data);
  endtask

  initial begin
    int beats_seen;
    int dones_seen;

    //               start ready up | valid last busy done data
    vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B0};
    vec[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B1};
    vec[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, B2};
    vec[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0};
    vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vec[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B0};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B1};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B1};
    vec[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B1};
    vec[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B1};
    vec[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, B1};
    vec[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, B2};
    vec[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0};
    vec[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vec[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};

    i_rst            = 1'b1;
    i_channel_up     = 1'b1;
    i_tx_start_flag  = 1'b0;
    i_tx_stream_data = {B2, B1, B0};
    tx_if.tready     = 1'b1;
    rx_if.tdata      = '0;
    rx_if.tkeep      = '0;
    rx_if.tvalid     = 1'b0;
    rx_if.tlast      = 1'b0;
    repeat (3) tick();

    check_tx("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("reset_abort",   o_tx_abort,       1'b0);
    check("reset_rx_data", o_rx_stream_data, '0);
    check("reset_rx_end",  o_rx_end_flag,    1'b0);
    check("reset_rx_err",  o_rx_len_err,     1'b0);

    i_rst = 1'b0;
    repeat (2) tick();

    // TX table: basic frame, level hold, tready stall with an extra edge in SEND.
    for (int i = 0; i < NVEC; i++) begin
      i_tx_start_flag = vec[i].start;
      tx_if.tready    = vec[i].ready;
      i_channel_up    = vec[i].up;
      tick();
      check_tx($sformatf("txvec%0d", i), vec[i].valid, vec[i].last,
               vec[i].busy, vec[i].done, vec[i].data);
    end

    // Start held high for 20+ cycles: exactly one frame of three beats.
    beats_seen = 0;
    dones_seen = 0;
    tx_if.tready    = 1'b1;
    i_tx_start_flag = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (tx_if.tvalid && tx_if.tready) beats_seen++;
      if (o_tx_done) dones_seen++;
    end
    check("hold_beats", beats_seen, 3);
    check("hold_dones", dones_seen, 1);
    i_tx_start_flag = 1'b0;
    tick();

    // Channel drop after beat 0 is accepted aborts the frame.
    i_tx_start_flag = 1'b1;
    tick();
    check_tx("abort_b0", 1'b1, 1'b0, 1'b1, 1'b0, B0);
    tick();
    check_tx("abort_b1", 1'b1, 1'b0, 1'b1, 1'b0, B1);
    i_channel_up = 1'b0;
    tick();
    check_tx("abort_hit", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("abort_pulse", o_tx_abort, 1'b1);
    tick();
    check("abort_pulse_end", o_tx_abort, 1'b0);
    i_tx_start_flag = 1'b0;
    tick();
    i_tx_start_flag = 1'b1;
    tick();
    check_tx("edge_while_down", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    i_tx_start_flag = 1'b0;
    i_channel_up    = 1'b1;
    tick();
    check_tx("no_pending", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    i_tx_start_flag = 1'b1;
    tick();
    check_tx("resend_b0", 1'b1, 1'b0, 1'b1, 1'b0, B0);
    tick();
    check_tx("resend_b1", 1'b1, 1'b0, 1'b1, 1'b0, B1);
    tick();
    check_tx("resend_b2", 1'b1, 1'b1, 1'b1, 1'b0, B2);
    tick();
    check_tx("resend_done", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    i_tx_start_flag = 1'b0;
    tick();

    // RX good frame.
    rx_beat(RA, 1'b0);
    check("rx1_a_end", o_rx_end_flag, 1'b0);
    rx_beat(RB, 1'b0);
    rx_beat(RC, 1'b1);
    check("rx1_end",  o_rx_end_flag,    1'b1);
    check("rx1_data", o_rx_stream_data, {RC, RB, RA});
    check("rx1_err",  o_rx_len_err,     1'b0);
    tick();
    check("rx1_end_pulse", o_rx_end_flag, 1'b0);

    // Short frame then long frame: two errors, word unchanged.
    rx_beat(64'hDEAD_0000_0000_0001, 1'b0);
    rx_beat(64'hDEAD_0000_0000_0002, 1'b1);
    check("short_err",  o_rx_len_err,     1'b1);
    check("short_end",  o_rx_end_flag,    1'b0);
    check("short_data", o_rx_stream_data, {RC, RB, RA});
    rx_beat(64'hBEEF_0000_0000_0001, 1'b0);
    check("long_b1_err", o_rx_len_err, 1'b0);
    rx_beat(64'hBEEF_0000_0000_0002, 1'b0);
    rx_beat(64'hBEEF_0000_0000_0003, 1'b0);
    check("long_err", o_rx_len_err, 1'b1);
    rx_beat(64'hBEEF_0000_0000_0004, 1'b1);
    check("long_tail_err",  o_rx_len_err,     1'b0);
    check("long_tail_end",  o_rx_end_flag,    1'b0);
    check("long_tail_data", o_rx_stream_data, {RC, RB, RA});
    rx_beat(RJ, 1'b0);
    rx_beat(RK, 1'b0);
    rx_beat(RL, 1'b1);
    check("rx2_end",  o_rx_end_flag,    1'b1);
    check("rx2_data", o_rx_stream_data, {RL, RK, RJ});

    // Channel loss mid-frame discards the partial beat without an error.
    rx_beat(64'hFFFF_0000_0000_00FF, 1'b0);
    i_channel_up = 1'b0;
    tick();
    check("rx_down_err", o_rx_len_err, 1'b0);
    i_channel_up = 1'b1;
    rx_beat(RN, 1'b0);
    rx_beat(RO, 1'b0);
    rx_beat(RP, 1'b1);
    check("rx3_end",  o_rx_end_flag,    1'b1);
    check("rx3_err",  o_rx_len_err,     1'b0);
    check("rx3_data", o_rx_stream_data, {RP, RO, RN});

    // Reset in the middle of a stalled TX frame.
    tx_if.tready    = 1'b0;
    i_tx_start_flag = 1'b1;
    tick();
    check("rst_pre_valid", tx_if.tvalid, 1'b1);
    i_rst = 1'b1;
    tick();
    check_tx("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_mid_rx_data", o_rx_stream_data, '0);
    i_rst           = 1'b0;
    i_tx_start_flag = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfp_aurora_axis_framer.md
Name: sfp_aurora_axis_framer

Overview:
- Aurora-side counterpart of the SFP data handler.
- TX path: on a start flag, captures the full stream word and sends it as an AXIS frame of C_NUMBER_OF_SLAVE*C_NUMBER_OF_FRAME beats into the Aurora TX user interface.
- RX path: reassembles the Aurora RX AXIS frame into one stream word and pulses an end flag when a complete, correctly sized frame has arrived.
- Sits between the data handler (stream/flag side) and the Aurora 64B/66B core (AXIS side).

Parameters:
- C_AXIS_TDATA_WIDTH, 64, AXIS beat width in bits.
- C_NUMBER_OF_SLAVE, 3, number of slaves in the chain.
- C_NUMBER_OF_FRAME, 1, frames per slave.
- C_BEATS, C_NUMBER_OF_SLAVE*C_NUMBER_OF_FRAME, beats per frame (derived; must be >= 2).
- C_DATA_BIT, C_AXIS_TDATA_WIDTH*C_BEATS, stream word width (derived).

Ports:
- i_clk  in  1  single clock for both paths.
- i_rst  in  1  synchronous reset, active-high.
- i_channel_up  in  1  Aurora channel up.
- i_tx_start_flag  in  1  TX request; its rising edge starts a frame.
- i_tx_stream_data  in  C_DATA_BIT  stream word to send.
- o_tx_busy  out  1  TX frame in progress.
- o_tx_done  out  1  one-cycle pulse after the last beat is accepted.
- o_tx_abort  out  1  one-cycle pulse when a frame is aborted by channel loss.
- m_axis_tx_tdata  out  C_AXIS_TDATA_WIDTH  TX beat data.
- m_axis_tx_tkeep  out  C_AXIS_TDATA_WIDTH/8  always all ones while tvalid is high.
- m_axis_tx_tvalid  out  1  TX beat valid.
- m_axis_tx_tlast  out  1  last beat of the frame.
- m_axis_tx_tready  in  1  Aurora ready.
- s_axis_rx_tdata  in  C_AXIS_TDATA_WIDTH  RX beat data.
- s_axis_rx_tkeep  in  C_AXIS_TDATA_WIDTH/8  ignored; partial beats are not used.
- s_axis_rx_tvalid  in  1  RX beat valid; there is no backpressure.
- s_axis_rx_tlast  in  1  RX last beat.
- o_rx_stream_data  out  C_DATA_BIT  last complete received word.
- o_rx_end_flag  out  1  one-cycle pulse when o_rx_stream_data is updated.
- o_rx_len_err  out  1  one-cycle pulse when a malformed RX frame is discarded.

Behaviour:
- Reset: all outputs 0; o_rx_stream_data cleared; TX FSM in IDLE; RX beat counter 0; start edge detector register cleared.
- Beat order, both paths: beat k carries stream bits [(k+1)*W-1 : k*W], where W = C_AXIS_TDATA_WIDTH. Beat 0 is the LSBs and is sent first.
- TX FSM states are IDLE, SEND and DONE.
  - IDLE: when the start flag has a rising edge at cycle t and i_channel_up=1, latch i_tx_stream_data at t. At t+1, tvalid=1 with beat 0, o_tx_busy=1 and the state is SEND.
  - A rising edge while i_channel_up=0 is dropped; no pending request is stored.
  - SEND: the beat index advances only on tvalid&tready. tdata/tlast stay stable while tready=0 (AXIS rule: tvalid never drops before the handshake). tlast=1 only on beat C_BEATS-1.
  - When the last beat is accepted at cycle t: at t+1 tvalid=0, o_tx_done=1, o_tx_busy=0 and the state is DONE. DONE returns to IDLE unconditionally at the next cycle.
  - A start edge during SEND or DONE is ignored. The edge detector keeps tracking, so a level held high never retriggers.
  - i_channel_up falling during SEND: next cycle tvalid=0, tlast=0, o_tx_abort pulses, o_tx_busy=0, state IDLE. The partial frame is not resumed.
- RX path:
  - Always accepts; a beat is a cycle with s_axis_rx_tvalid=1.
  - Beat at counter index c is written into the shadow buffer slice c, then c increments.
  - tlast with c=C_BEATS-1: at the next cycle o_rx_stream_data = shadow (including this beat), o_rx_end_flag=1 for one cycle, and c resets to 0.
  - tlast with c<C_BEATS-1 (short frame): discard, o_rx_len_err pulse, c=0; o_rx_stream_data is unchanged.
  - Beat at c=C_BEATS-1 without tlast (long frame): discard, o_rx_len_err pulse once, then drop beats until tlast and restart at c=0 after it.
  - i_channel_up=0: c forced to 0, partial data discarded, no error pulse.
- TX and RX are fully independent; simultaneous TX done and RX end in one cycle are both reported.
- Reset mid-frame: immediate return to the reset state. tvalid is 0 from the next cycle.

Decomposition:
- Package sfp_aurora_pkg: TX state enum (IDLE/SEND/DONE), a beat-index width function clog2(C_BEATS), and a helper function for the slice of beat k.
- Sub-module sfp_aurora_rx_assembler: the RX counter, shadow buffer and error logic. The TX FSM stays in the top.

Test Plan:
- C_BEATS=3, tready tied 1, i_tx_stream_data=0x0003..._0002..._0001 (one value per beat), start edge at cycle 10 -> beats 1,2,3 at cycles 11,12,13; tlast at 13 only; o_tx_done at 14; o_tx_busy high for cycles 11-13.
- tready low for 4 cycles on beat 1 -> tdata holds beat 1 and tvalid stays high; frame completes 4 cycles later with no beat skipped or duplicated.
- Start held high for 20 cycles after the frame ends -> exactly one frame is sent; a second edge during SEND produces no second frame.
- RX 3 beats A,B,C with tlast on C -> one cycle later o_rx_stream_data={C,B,A} and o_rx_end_flag pulses once.
- RX 2 beats with tlast, then a 4-beat frame with tlast on beat 4 -> two o_rx_len_err pulses; o_rx_stream_data unchanged; a following good 3-beat frame is accepted.
- i_channel_up dropped after beat 1 of TX -> o_tx_abort pulses, tvalid=0; the next start edge after channel up sends a full 3-beat frame.
